// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state codes, default width
// and the two's-complement magnitude helper.
package cpu_div_pkg;
   localparam int DEFAULT_WIDTH = 32;
   localparam int MAX_W         = 64;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] PREP = 3'd1;
   localparam logic [2:0] ITER = 3'd2;
   localparam logic [2:0] FIX  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   // Magnitude of the w-bit two's-complement value held in the low bits of v.
   // The most negative value maps to itself, which is its unsigned magnitude.
   function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] v, input int unsigned w);
      logic [MAX_W-1:0] mask;
      mask = (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
      if (((v >> (w - 1)) & MAX_W'(1)) != '0)
         return (~v + MAX_W'(1)) & mask;
      return v & mask;
   endfunction
endpackage

// File: rtl/seq_divider_if.sv
// Operand/result bundle between the ALU sequencer and the divider.
interface seq_divider_if import cpu_div_pkg::*; #(parameter int WIDTH = DEFAULT_WIDTH);
   logic               start;
   logic               signed_op;
   logic [WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]   divisor;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
   logic [2*WIDTH-1:0] z_out;
   logic               div0;
   logic               ovf;

   modport master (
      output start, signed_op, dividend, divisor,
      input  busy, done, quotient, remainder, z_out, div0, ovf
   );
   modport slave (
      input  start, signed_op, dividend, divisor,
      output busy, done, quotient, remainder, z_out, div0, ovf
   );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract if it fits.
module div_step import cpu_div_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] r,
   input  logic             a_msb,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r_next,
   output logic             q_bit
);
   // The shifted remainder needs one extra bit: r < b can still overflow WIDTH bits after the shift.
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   always_comb begin
      shifted = {r, a_msb};
      diff    = shifted[WIDTH-1:0] - b;
      q_bit   = (shifted >= {1'b0, b});
      r_next  = q_bit ? diff : shifted[WIDTH-1:0];
   end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, one quotient bit per cycle, results held
// in dedicated output registers that update only when an operation completes.
module seq_divider import cpu_div_pkg::*; #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input logic          clk,
   input logic          clr,
   seq_divider_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dvd_raw_q, dvd_raw_d, dvs_raw_q, dvs_raw_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
   logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
   logic             sgn_op_q, sgn_op_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
   logic             zero_div_q, zero_div_d, div0_q, div0_d, ovf_q, ovf_d;
   logic [WIDTH-1:0] r_step;
   logic             q_step;

   div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r_q),
      .a_msb  (a_q[WIDTH-1]),
      .b      (b_q),
      .r_next (r_step),
      .q_bit  (q_step)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dvd_raw_d  = dvd_raw_q;
      dvs_raw_d  = dvs_raw_q;
      a_d        = a_q;
      b_d        = b_q;
      r_d        = r_q;
      quot_d     = quot_q;
      rem_d      = rem_q;
      sgn_op_d   = sgn_op_q;
      neg_q_d    = neg_q_q;
      neg_r_d    = neg_r_q;
      zero_div_d = zero_div_q;
      div0_d     = div0_q;
      ovf_d      = ovf_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               dvd_raw_d = bus.dividend;
               dvs_raw_d = bus.divisor;
               sgn_op_d  = bus.signed_op;
               div0_d    = 1'b0;
               ovf_d     = 1'b0;
               state_d   = PREP;
            end
         end
         PREP: begin
            a_d        = sgn_op_q ? WIDTH'(abs_w(MAX_W'(dvd_raw_q), WIDTH)) : dvd_raw_q;
            b_d        = sgn_op_q ? WIDTH'(abs_w(MAX_W'(dvs_raw_q), WIDTH)) : dvs_raw_q;
            neg_q_d    = sgn_op_q & (dvd_raw_q[WIDTH-1] ^ dvs_raw_q[WIDTH-1]);
            neg_r_d    = sgn_op_q & dvd_raw_q[WIDTH-1];
            zero_div_d = (dvs_raw_q == '0);
            r_d        = '0;
            cnt_d      = '0;
            state_d    = (dvs_raw_q == '0) ? FIX : ITER;
         end
         ITER: begin
            // The dividend register shifts left and collects quotient bits in its LSB.
            r_d   = r_step;
            a_d   = {a_q[WIDTH-2:0], q_step};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1))
               state_d = FIX;
         end
         FIX: begin
            if (zero_div_q) begin
               quot_d = '1;
               rem_d  = dvd_raw_q;
               div0_d = 1'b1;
            end else begin
               quot_d = neg_q_q ? -a_q : a_q;
               rem_d  = neg_r_q ? -r_q : r_q;
               ovf_d  = sgn_op_q && (dvd_raw_q == MIN_VAL) && (dvs_raw_q == '1);
            end
            state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         dvd_raw_q  <= '0;
         dvs_raw_q  <= '0;
         a_q        <= '0;
         b_q        <= '0;
         r_q        <= '0;
         quot_q     <= '0;
         rem_q      <= '0;
         sgn_op_q   <= 1'b0;
         neg_q_q    <= 1'b0;
         neg_r_q    <= 1'b0;
         zero_div_q <= 1'b0;
         div0_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dvd_raw_q  <= dvd_raw_d;
         dvs_raw_q  <= dvs_raw_d;
         a_q        <= a_d;
         b_q        <= b_d;
         r_q        <= r_d;
         quot_q     <= quot_d;
         rem_q      <= rem_d;
         sgn_op_q   <= sgn_op_d;
         neg_q_q    <= neg_q_d;
         neg_r_q    <= neg_r_d;
         zero_div_q <= zero_div_d;
         div0_q     <= div0_d;
         ovf_q      <= ovf_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quot_q;
   assign bus.remainder = rem_q;
   assign bus.z_out     = {rem_q, quot_q};
   assign bus.div0      = div0_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed vector bench for seq_divider (WIDTH=32) plus handshake/reset corner sequences.
module tb_seq_divider;
   import cpu_div_pkg::*;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      logic        d0;
      logic        ov;
      int          lat;
   } vec_t;

   logic clk;
   logic clr;
   int   total;
   int   bad;

   seq_divider_if #(.WIDTH(32)) dif ();

   seq_divider #(.WIDTH(32)) dut (
      .clk (clk),
      .clr (clr),
      .bus (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic run_op(input vec_t v, input string nm);
      int  n;
      bit  seen;
      dif.signed_op = v.sgn;
      dif.dividend  = v.a;
      dif.divisor   = v.b;
      dif.start     = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      check({nm, "_busy"}, 64'(dif.busy), 64'd1);
      n    = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (dif.done) seen = 1;
      end
      check({nm, "_latency"}, 64'(n), 64'(v.lat));
      check({nm, "_quot"}, 64'(dif.quotient), 64'(v.q));
      check({nm, "_rem"}, 64'(dif.remainder), 64'(v.r));
      check({nm, "_zout"}, dif.z_out, {v.r, v.q});
      check({nm, "_div0"}, 64'(dif.div0), 64'(v.d0));
      check({nm, "_ovf"}, 64'(dif.ovf), 64'(v.ov));
      $display("op %s sgn=%0d %h / %h -> q=%h r=%h div0=%0d ovf=%0d lat=%0d",
               nm, v.sgn, v.a, v.b, dif.quotient, dif.remainder, dif.div0, dif.ovf, n);
      @(posedge clk);
      #1;
      check({nm, "_idle_busy"}, 64'(dif.busy), 64'd0);
      check({nm, "_idle_done"}, 64'(dif.done), 64'd0);
      check({nm, "_hold_quot"}, 64'(dif.quotient), 64'(v.q));
   endtask

   vec_t vecs [12];

   initial begin
      int   n;
      int   done_cnt;
      int   unstable;
      bit   seen;
      vec_t v;

      total = 0;
      bad   = 0;
      //            sgn  dividend      divisor       quotient      remainder     d0    ov   lat
      vecs[0]  = '{1'b1, 32'h00000002, 32'hFFFFFFF6, 32'h00000000, 32'h00000002, 1'b0, 1'b0, 34};
      vecs[1]  = '{1'b1, 32'hFFFFFFF6, 32'h00000003, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
      vecs[2]  = '{1'b0, 32'hFFFFFFFF, 32'h00000002, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 34};
      vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0, 1'b1, 34};
      vecs[4]  = '{1'b0, 32'h00000007, 32'h00000000, 32'hFFFFFFFF, 32'h00000007, 1'b1, 1'b0, 2};
      vecs[5]  = '{1'b0, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 34};
      vecs[6]  = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 34};
      vecs[7]  = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 1'b0, 1'b0, 34};
      vecs[8]  = '{1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 34};
      vecs[9]  = '{1'b0, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, 1'b0, 1'b0, 34};
      vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1, 1'b0, 2};
      vecs[11] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 34};

      dif.start     = 1'b0;
      dif.signed_op = 1'b0;
      dif.dividend  = '0;
      dif.divisor   = '0;
      clr           = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 64'(dif.busy), 64'd0);
      check("rst_done", 64'(dif.done), 64'd0);
      check("rst_zout", dif.z_out, 64'd0);
      check("rst_div0", 64'(dif.div0), 64'd0);
      check("rst_ovf", 64'(dif.ovf), 64'd0);
      clr = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++)
         run_op(vecs[i], $sformatf("v%0d", i));

      // Start held high with operands churning: only the first op runs, one done pulse.
      dif.signed_op = 1'b0;
      dif.dividend  = 32'd100;
      dif.divisor   = 32'd7;
      dif.start     = 1'b1;
      @(posedge clk);
      #1;
      n        = 0;
      seen     = 0;
      done_cnt = 0;
      unstable = 0;
      while (!seen && n < 100) begin
         if (dif.quotient !== 32'h1 || dif.remainder !== 32'h1) unstable++;
         dif.dividend = $urandom;
         dif.divisor  = $urandom;
         @(posedge clk);
         n++;
         #1;
         if (dif.done) begin
            seen = 1;
            done_cnt++;
         end
      end
      check("t5_latency", 64'(n), 64'd34);
      check("t5_hold_while_busy", 64'(unstable), 64'd0);
      check("t5_quot", 64'(dif.quotient), 64'd14);
      check("t5_rem", 64'(dif.remainder), 64'd2);
      $display("op t5 first q=%h r=%h lat=%0d", dif.quotient, dif.remainder, n);
      dif.dividend = 32'd20;
      dif.divisor  = 32'd18;
      @(posedge clk);
      #1;
      if (dif.done) done_cnt++;
      check("t5_ignored_in_done", 64'(dif.busy), 64'd0);
      @(posedge clk);
      #1;
      if (dif.done) done_cnt++;
      check("t5_accept_next_idle", 64'(dif.busy), 64'd1);
      check("t5_single_done", 64'(done_cnt), 64'd1);
      dif.start = 1'b0;
      n    = 0;
      seen = 0;
      while (!seen && n < 100) begin
         @(posedge clk);
         n++;
         #1;
         if (dif.done) seen = 1;
      end
      check("t5_second_latency", 64'(n), 64'd34);
      check("t5_second_quot", 64'(dif.quotient), 64'd1);
      check("t5_second_rem", 64'(dif.remainder), 64'd2);
      $display("op t5 second q=%h r=%h lat=%0d", dif.quotient, dif.remainder, n);
      @(posedge clk);
      #1;

      // Asynchronous clear in the middle of the iteration phase.
      dif.signed_op = 1'b1;
      dif.dividend  = 32'hFFFFFF00;
      dif.divisor   = 32'd3;
      dif.start     = 1'b1;
      @(posedge clk);
      #1;
      dif.start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("t6_busy_before_clr", 64'(dif.busy), 64'd1);
      clr = 1'b0;
      #1;
      check("t6_clr_busy", 64'(dif.busy), 64'd0);
      check("t6_clr_done", 64'(dif.done), 64'd0);
      check("t6_clr_zout", dif.z_out, 64'd0);
      $display("op t6 clr mid-iteration busy=%0d z=%h", dif.busy, dif.z_out);
      @(negedge clk);
      clr = 1'b1;
      @(posedge clk);
      #1;
      v = '{1'b0, 32'd20, 32'd18, 32'd1, 32'd2, 1'b0, 1'b0, 34};
      run_op(v, "t6_after");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
